// File: rtl/nios_pio_pkg.sv
// nios_pio_pkg: shared register map and edge-type encodings for the button PIO
package nios_pio_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: one-bit synchroniser chain followed by a hold-time debouncer
//  clk, reset_n (async, active-low) ; din raw async input ; deb accepted level
module pio_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] chain;
  logic [CW-1:0] count;
  logic sync;
  assign sync = chain[SYNC_STAGES-1];
  // A new level is accepted only after it has differed from deb for DEBOUNCE_CYCLES
  // consecutive cycles; any return to deb restarts the count.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      chain <= '0;
      count <= '0;
      deb   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      if (sync == deb) count <= '0;
      else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb   <= sync;
        count <= '0;
      end else count <= count + 1'b1;
    end
endmodule

// File: rtl/nios_button_pio.sv
// nios_button_pio: Avalon-MM input PIO with debounce, edge capture and maskable irq
//  clk, reset_n (async, active-low)
//  address/chipselect/read_n/write_n/writedata : Avalon-MM slave, read latency 1
//  in_port : raw board inputs ; readdata : registered read data ; irq : level interrupt
module nios_button_pio
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] deb, deb_prev, irq_mask, edge_capture, evt, clr;
  logic [31:0] rd_mux;
  logic wr, rd, unused_wdata;
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk(clk),
      .reset_n(reset_n),
      .din(in_port[g]),
      .deb(deb[g])
    );
  end
  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;
  assign unused_wdata = &{1'b0, writedata};
  assign evt = EDGE_TYPE == EDGE_RISE ? deb & ~deb_prev :
               EDGE_TYPE == EDGE_FALL ? ~deb & deb_prev : deb ^ deb_prev;
  assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  always_comb
    rd_mux = address == ADDR_DATA    ? 32'(deb) :
             address == ADDR_IRQMASK ? 32'(irq_mask) :
             address == ADDR_EDGECAP ? 32'(edge_capture) : '0;
  // A new event is OR'ed in after the W1C mask so it survives a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      deb_prev     <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      deb_prev     <= deb;
      edge_capture <= (edge_capture & ~clr) | evt;
      if (wr && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      readdata     <= rd ? rd_mux : '0;
      irq          <= |(edge_capture & irq_mask);
    end
endmodule

// File: tb/tb_nios_button_pio.sv
// tb_nios_button_pio: directed self-checking bench for nios_button_pio
module tb_nios_button_pio;
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] address;
  logic chipselect, read_n, write_n;
  logic [31:0] writedata, readdata, d;
  logic [3:0] in_port;
  logic irq;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios_button_pio #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .read_n(read_n),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    v = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  initial begin
    reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = 2'd0; writedata = '0;
    wait_n(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    wait_n(5);
    bus_read(2'd0, d); check("data_early", d, 32'h0);
    bus_read(2'd0, d); check("data_settled", d, 32'hF);
    wait_n(1);
    check("idle_readdata", readdata, 32'h0);
    bus_read(2'd3, d); check("edgecap_after_rst", d, 32'h0);
    check("irq_after_rst", {31'b0, irq}, 32'h0);
    bus_read(2'd1, d); check("rsvd_zero", d, 32'h0);
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, d); check("data_write_ignored", d, 32'hF);
    // glitch of 3 cycles must be rejected
    in_port = 4'hE; wait_n(3); in_port = 4'hF; wait_n(10);
    bus_read(2'd0, d); check("glitch_data", d, 32'hF);
    bus_read(2'd3, d); check("glitch_edgecap", d, 32'h0);
    in_port = 4'hE; wait_n(10);
    bus_read(2'd0, d); check("press_data", d, 32'hE);
    bus_read(2'd3, d); check("press_edgecap", d, 32'h1);
    in_port = 4'hF; wait_n(10);
    bus_read(2'd3, d); check("rise_not_captured", d, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d); check("w1c_clear", d, 32'h0);
    // irq timing
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, d); check("irqmask_rb", d, 32'h1);
    in_port = 4'hE; wait_n(7);
    check("irq_before", {31'b0, irq}, 32'h0);
    wait_n(1);
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_hold", {31'b0, irq}, 32'h1);
    wait_n(1);
    check("irq_drop", {31'b0, irq}, 32'h0);
    in_port = 4'hF; wait_n(10);
    // masking
    in_port = 4'hB; wait_n(10);
    bus_read(2'd3, d); check("mask_edgecap", d, 32'h4);
    check("mask_irq_off", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h4);
    check("mask_irq_lag", {31'b0, irq}, 32'h0);
    wait_n(1);
    check("mask_irq_on", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h4);
    in_port = 4'hF; wait_n(10);
    check("mask_irq_clr", {31'b0, irq}, 32'h0);
    bus_read(2'd3, d); check("mask_edgecap_clr", d, 32'h0);
    // W1C racing a new edge on bit1
    in_port = 4'hE; wait_n(10);
    bus_read(2'd3, d); check("race_pre", d, 32'h1);
    in_port = 4'hC; wait_n(6);
    bus_write(2'd3, 32'h3);
    bus_read(2'd3, d); check("race_edgecap", d, 32'h2);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, d); check("race_cleared", d, 32'h0);
    // reset in the middle of a debounce count
    in_port = 4'hF; wait_n(10);
    in_port = 4'hE; wait_n(3);
    bus_read(2'd0, d); check("midrst_pre", d, 32'hF);
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    wait_n(2);
    reset_n = 1'b1;
    wait_n(5);
    bus_read(2'd0, d); check("midrst_data_early", d, 32'h0);
    bus_read(2'd0, d); check("midrst_data", d, 32'hE);
    bus_read(2'd2, d); check("midrst_irqmask", d, 32'h0);
    bus_read(2'd3, d); check("midrst_edgecap", d, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
